gray_sync_rx: RTL and testbench

Receive-side stage for the `gray_counter` output. It brings a Gray-coded count from a foreign clock domain into `clk` through a multi-flop synchronizer and decodes it to binary. It also reports the per-sample increment and flags any sample that violates the single-bit-change rule. It feeds FIFO occupancy logic and rate monitors that need a safe binary view of a remote counter.

---
 rtl/gray_pkg.sv | 44 ++++
 rtl/sync_ff.sv | 42 ++++
 rtl/gray_sync_rx.sv | 137 +++++++++++++
 tb/tb_gray_sync_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg
// Shared helpers for Gray-coded count handling:
//   g2b / b2g  : Gray <-> binary conversion on a GMAX-bit word. Narrower
//                counts are zero-extended on the way in and truncated on the
//                way out; the zero upper bits leave the result unchanged.
//   popcount   : number of set bits in a GMAX-bit word.
//   rx_state_e : receive-side sequencing states.
package gray_pkg;

    // Widest count the helpers support.
    localparam int GMAX = 32;

    typedef logic [GMAX-1:0] gword_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        INIT  = 2'd1,
        TRACK = 2'd2
    } rx_state_e;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic gword_t g2b(input gword_t s);
        gword_t b;
        b[GMAX-1] = s[GMAX-1];
        for (int i = GMAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ s[i];
        end
        return b;
    endfunction

    function automatic gword_t b2g(input gword_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input gword_t v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < GMAX; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff
// Plain multi-flop synchronizer for a bus arriving from another clock
// domain. Nothing but wires sits between the flops.
//   clk   : destination clock
//   rst_n : asynchronous reset, active-high
//   d     : W-bit asynchronous input
//   q     : W-bit output, STAGES flops after d
module sync_ff #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain_q [STAGES];
    logic [W-1:0] chain_d [STAGES];

    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= chain_d[i];
            end
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/gray_sync_rx.sv
// gray_sync_rx
// Brings a Gray-coded count from a foreign clock domain into clk, decodes it
// to binary, reports the per-sample increment and flags samples that change
// more than one Gray bit.
//   clk     : receive clock
//   rst_n   : asynchronous reset, active-high
//   gray_in : W-bit Gray count, asynchronous to clk
//   err_clr : synchronous clear of the sticky err flag
//   valid   : decoded outputs are meaningful
//   bin     : decoded binary count
//   delta   : bin minus previous bin, modulo 2^W
//   step    : pulse when delta == 1
//   err     : sticky multi-bit-change flag
//
// state | meaning
// FILL  | sync chain flushing after reset, outputs held at reset values
// INIT  | first sample loaded, no delta or error check
// TRACK | decode, delta and error check every cycle
//
// W is limited to gray_pkg::GMAX bits.
module gray_sync_rx
    import gray_pkg::*;
#(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] gray_in,
    input  logic         err_clr,
    output logic         valid,
    output logic [W-1:0] bin,
    output logic [W-1:0] delta,
    output logic         step,
    output logic         err
);

    localparam logic [1:0] FILL_LAST = 2'(STAGES - 1);

    logic [W-1:0] g_sync;

    sync_ff #(
        .W      (W),
        .STAGES (STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_in),
        .q     (g_sync)
    );

    rx_state_e    state_q, state_d;
    logic [1:0]   fill_cnt_q, fill_cnt_d;
    logic [W-1:0] g_prev_q, g_prev_d;
    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] delta_q, delta_d;
    logic         valid_q, valid_d;
    logic         step_q, step_d;
    logic         err_q, err_d;

    logic [W-1:0] bin_dec;
    logic         multi_bit;

    always_comb begin
        bin_dec   = W'(g2b(GMAX'(g_sync)));
        multi_bit = popcount(GMAX'(g_sync ^ g_prev_q)) > 6'd1;

        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        g_prev_d   = g_prev_q;
        bin_d      = bin_q;
        delta_d    = delta_q;
        valid_d    = valid_q;
        step_d     = step_q;
        err_d      = err_q & ~err_clr;

        case (state_q)
            FILL: begin
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = INIT;
                end else begin
                    fill_cnt_d = fill_cnt_q + 2'd1;
                end
            end
            INIT: begin
                g_prev_d = g_sync;
                bin_d    = bin_dec;
                delta_d  = '0;
                step_d   = 1'b0;
                valid_d  = 1'b1;
                state_d  = TRACK;
            end
            TRACK: begin
                g_prev_d = g_sync;
                bin_d    = bin_dec;
                delta_d  = bin_dec - bin_q;
                step_d   = (bin_dec - bin_q) == W'(1);
                // A violation in the same cycle as err_clr keeps err set.
                if (multi_bit) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            g_prev_q   <= '0;
            bin_q      <= '0;
            delta_q    <= '0;
            valid_q    <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            g_prev_q   <= g_prev_d;
            bin_q      <= bin_d;
            delta_q    <= delta_d;
            valid_q    <= valid_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign valid = valid_q;
    assign bin   = bin_q;
    assign delta = delta_q;
    assign step  = step_q;
    assign err   = err_q;

endmodule

// File: tb/tb_gray_sync_rx.sv
module tb_gray_sync_rx;

    localparam int W      = 4;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gray_in;
    logic         err_clr;
    logic         valid;
    logic [W-1:0] bin;
    logic [W-1:0] delta;
    logic         step;
    logic         err;

    gray_sync_rx #(.W(W), .STAGES(STAGES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gray_in (gray_in),
        .err_clr (err_clr),
        .valid   (valid),
        .bin     (bin),
        .delta   (delta),
        .step    (step),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of Gray values seen at each edge since reset
    // release, and the expected outputs derived from it.
    int           ecount;
    logic [W-1:0] gh[$];
    logic         ev, es, eerr;
    logic [W-1:0] eb, ed;
    logic [W-1:0] cur_b;

    function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic string got_s();
        return $sformatf("v=%b bin=%0d d=%0d s=%b e=%b", valid, bin, delta, step, err);
    endfunction

    function automatic string exp_s();
        return $sformatf("v=%b bin=%0d d=%0d s=%b e=%b", ev, eb, ed, es, eerr);
    endfunction

    task automatic model_reset();
        ecount = 0;
        gh.delete();
        ev = 0; eb = '0; ed = '0; es = 0; eerr = 0;
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, advance the
    // model, return at the next negedge.
    task automatic cycle(input logic [W-1:0] g, input logic clr);
        logic [W-1:0] nb;
        gray_in = g;
        err_clr = clr;
        @(posedge clk);
        ecount++;
        gh.push_back(g);
        if (ecount == STAGES + 1) begin
            ev = 1; eb = to_bin(gh[0]); ed = '0; es = 0;
        end else if (ecount > STAGES + 1) begin
            nb = to_bin(gh[ecount-1-STAGES]);
            ed = nb - eb;
            eb = nb;
            es = (ed == W'(1));
            if ($countones(gh[ecount-1-STAGES] ^ gh[ecount-2-STAGES]) > 1) eerr = 1;
            else if (clr) eerr = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1; gray_in = 4'b0110; err_clr = 0;
        #1;
        n_cmp++;
        if ({valid, bin, delta, step, err} !== '0) begin
            n_bad++; $display("FAIL reset_state: got %s, expected all zero", got_s());
        end
        @(negedge clk);
        rst_n = 0;
        model_reset();
        for (int i = 0; i < STAGES + 1; i++) begin
            cycle(4'b0110, 0);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL reset_fill edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
        end
        n_cmp++;
        if (valid !== 1'b1 || bin !== 4'd4 || delta !== 4'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: got %s, expected v=1 bin=4 d=0 e=0", got_s());
        end
        cur_b = 4'd4;
    endtask

    task automatic test_count();
        int changes;
        changes = 0;
        while (changes < 200 || cur_b != 4'd6) begin
            cur_b++;
            changes++;
            repeat ($urandom_range(1, 3)) begin
                cycle(to_gray(cur_b), 0);
                n_cmp++;
                if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                    n_bad++; $display("FAIL count edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
                end
            end
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL count_err: got err=%b, expected 0", err);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0101, 0);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL stall edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
            if (i >= STAGES + 1) begin
                n_cmp++;
                if (bin !== 4'd6 || delta !== 4'd0 || step !== 1'b0) begin
                    n_bad++; $display("FAIL stall_hold: got %s, expected bin=6 d=0 s=0", got_s());
                end
            end
        end
    endtask

    task automatic test_jump();
        while (cur_b != 4'd0) begin
            cur_b++;
            cycle(to_gray(cur_b), 0);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL ramp edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
        end
        repeat (STAGES + 2) cycle(4'b0000, 0);
        for (int i = 0; i < STAGES + 4; i++) begin
            cycle(4'b0011, 0);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL jump edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
            if (i == STAGES) begin
                n_cmp++;
                if (bin !== 4'd2 || delta !== 4'd2 || err !== 1'b1) begin
                    n_bad++; $display("FAIL jump_detect: got %s, expected bin=2 d=2 e=1", got_s());
                end
            end
        end
        cycle(4'b0011, 1);
        n_cmp++;
        if (err !== 1'b0 || eerr !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got err=%b, expected 0 (model %b)", err, eerr);
        end
        cycle(4'b0011, 0);
        n_cmp++;
        if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
            n_bad++; $display("FAIL after_clear: got %s, expected %s", got_s(), exp_s());
        end
        cur_b = 4'd2;
    endtask

    task automatic test_set_wins();
        for (int i = 0; i < STAGES + 3; i++) begin
            cycle(4'b0000, 1);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL set_wins edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
            if (i == STAGES) begin
                n_cmp++;
                if (err !== 1'b1 || bin !== 4'd0 || delta !== 4'd14) begin
                    n_bad++; $display("FAIL set_wins_flag: got %s, expected bin=0 d=14 e=1", got_s());
                end
            end
        end
        cur_b = 4'd0;
    endtask

    task automatic test_random();
        logic [W-1:0] g;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) g = to_gray(cur_b + W'($urandom_range(0, 1)));
            else g = W'($urandom_range(0, 15));
            cur_b = to_bin(g);
            cycle(g, $urandom_range(0, 7) == 0);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL random edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
        end
    endtask

    task automatic test_midreset();
        while (cur_b != 4'd9) begin
            cur_b++;
            cycle(to_gray(cur_b), 0);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL pre_reset edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
        end
        repeat (STAGES + 1) cycle(to_gray(cur_b), 0);
        n_cmp++;
        if (bin !== 4'd9 || valid !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_bin: got %s, expected v=1 bin=9", got_s());
        end
        #2 rst_n = 1;
        #1;
        n_cmp++;
        if ({valid, bin, delta, step, err} !== '0) begin
            n_bad++; $display("FAIL midreset_async: got %s, expected all zero", got_s());
        end
        @(negedge clk);
        rst_n = 0;
        model_reset();
        for (int i = 0; i < STAGES + 1; i++) begin
            cycle(to_gray(cur_b), 0);
            n_cmp++;
            if ({valid, bin, delta, step, err} !== {ev, eb, ed, es, eerr}) begin
                n_bad++; $display("FAIL post_reset edge %0d: got %s, expected %s", ecount, got_s(), exp_s());
            end
        end
        n_cmp++;
        if (valid !== 1'b1 || bin !== 4'd9 || delta !== 4'd0) begin
            n_bad++; $display("FAIL post_reset_valid: got %s, expected v=1 bin=9 d=0", got_s());
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_stall();
        test_jump();
        test_set_wins();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
